mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the five-stage MIPS pipeline. It is fed from the E stage with forwarded operands and executes mult, multu, div, divu, mthi and mtlo. The `busy` flag drives the D-stage stall logic; `hi`/`lo` are read directly by mfhi/mflo in E. It replaces the inline HI/LO/busy logic in the pipeline top.

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed when a command is accepted and committed after a fixed busy window.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        p_wr_q, p_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  op_e         op_cmd;
  logic        finishing;
  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Datapath: products and a sign-magnitude divider; the magnitude form makes
  // 0x80000000 / -1 fall out as 0x80000000 with remainder 0 without a special case.
  always_comb begin
    op_cmd   = op_e'(op);
    prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
    prod_s   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    a_neg    = (op_cmd == OP_DIV) && rs_data[31];
    b_neg    = (op_cmd == OP_DIV) && rt_data[31];
    a_mag    = a_neg ? -rs_data : rs_data;
    b_mag    = b_neg ? -rt_data : rt_data;
    div_zero = (rt_data == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

  // On the final busy edge a new command is accepted in the same cycle as the commit;
  // a same-edge mthi/mtlo is younger than the retiring op, so it wins its register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    p_wr_d    = p_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    finishing = (state_q == RUN) && (cnt_q == 4'd1);
    accept    = start && ((state_q == IDLE) || finishing);

    if (state_q == RUN) begin
      if (finishing) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (p_wr_q) begin
          hi_d = p_hi_q;
          lo_d = p_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    if (accept) begin
      case (op_cmd)
        OP_MULT: begin
          p_hi_d  = prod_s[63:32];
          p_lo_d  = prod_s[31:0];
          p_wr_d  = 1'b1;
          cnt_d   = 4'(MULT_CYCLES);
          state_d = RUN;
        end
        OP_MULTU: begin
          p_hi_d  = prod_u[63:32];
          p_lo_d  = prod_u[31:0];
          p_wr_d  = 1'b1;
          cnt_d   = 4'(MULT_CYCLES);
          state_d = RUN;
        end
        OP_DIV, OP_DIVU: begin
          p_hi_d  = rem;
          p_lo_d  = quo;
          p_wr_d  = !div_zero;
          cnt_d   = 4'(DIV_CYCLES);
          state_d = RUN;
        end
        OP_MTHI: hi_d = rs_data;
        OP_MTLO: lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_wr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic results, busy timing,
// dropped commands while busy, back-to-back issue and asynchronous reset.
module tb_mult_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset_n),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a command for exactly one rising edge; returns 1ns after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 3'd7;
    rs_data = 32'hDEAD_BEEF;
    rt_data = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd7;
    rs_data = '0;
    rt_data = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_c0: got %b want 1", busy); end
    for (int i = 1; i < MC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_c%0d: got %b want 1", i, busy); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL mult_lo_stale_c%0d: got %h want 00000000", i, lo); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_end: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
  endtask

  task automatic test_multu_mthi;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i < MC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multu_busy_c%0d: got %b want 1", i, busy); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_end: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    issue(3'd4, 32'h1234_5678, 32'h0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL mthi_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    for (int i = 1; i < DC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy_c%0d: got %b want 1", i, busy); end
      n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL div_hi_stale_c%0d: got %h want 12345678", i, hi); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_busy_end: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DC) begin @(posedge clk); end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divovf_busy_end: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_div_zero;
    issue(3'd4, 32'h0000_00AA, 32'h0);
    issue(3'd5, 32'h0000_00BB, 32'h0);
    n_cmp++; if (hi !== 32'hAA) begin n_err++; $display("FAIL divz_pre_hi: got %h want 000000aa", hi); end
    n_cmp++; if (lo !== 32'hBB) begin n_err++; $display("FAIL divz_pre_lo: got %h want 000000bb", lo); end
    issue(3'd3, 32'h0000_1234, 32'h0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL divz_busy_c0: got %b want 1", busy); end
    for (int i = 1; i < DC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL divz_busy_c%0d: got %b want 1", i, busy); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divz_busy_end: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hAA) begin n_err++; $display("FAIL divz_hi: got %h want 000000aa", hi); end
    n_cmp++; if (lo !== 32'hBB) begin n_err++; $display("FAIL divz_lo: got %h want 000000bb", lo); end
  endtask

  task automatic test_ignore_while_busy;
    issue(3'd0, 32'd7, 32'd6);
    issue(3'd5, 32'h0000_0055, 32'h0);
    n_cmp++; if (lo !== 32'hBB) begin n_err++; $display("FAIL ign_mtlo_lo: got %h want 000000bb", lo); end
    issue(3'd2, 32'd100, 32'd3);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy_c2: got %b want 1", busy); end
    for (int i = 3; i < MC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy_c%0d: got %b want 1", i, busy); end
      n_cmp++; if (lo !== 32'hBB) begin n_err++; $display("FAIL ign_lo_c%0d: got %h want 000000bb", i, lo); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_end: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL ign_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0000_002A) begin n_err++; $display("FAIL ign_lo: got %h want 0000002a", lo); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_no_div: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    issue(3'd0, 32'd3, 32'd4);
    for (int i = 1; i < MC; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_last: got %b want 1", busy); end
    issue(3'd3, 32'd100, 32'd7);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_handoff: got %b want 1", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL b2b_mult_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0000_000C) begin n_err++; $display("FAIL b2b_mult_lo: got %h want 0000000c", lo); end
    for (int i = 1; i < DC; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_c%0d: got %b want 1", i, busy); end
    end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'h0000_000E) begin n_err++; $display("FAIL b2b_div_lo: got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL b2b_div_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_noop;
    issue(3'd6, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL op6_busy: got %b want 0", busy); end
    issue(3'd7, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL op7_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h2) begin n_err++; $display("FAIL noop_hi: got %h want 00000002", hi); end
    n_cmp++; if (lo !== 32'hE) begin n_err++; $display("FAIL noop_lo: got %h want 0000000e", lo); end
  endtask

  task automatic test_reset_mid;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (3) begin @(posedge clk); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h want 00000000", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_post_busy_c%0d: got %b want 0", i, busy); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_post_hi_c%0d: got %h want 00000000", i, hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_post_lo_c%0d: got %h want 00000000", i, lo); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_multu_mthi();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_back_to_back();
    test_noop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
